// File: rtl/seq_match_sched.sv
// Four-channel time-shared 3-symbol pattern matcher: a round-robin arbiter
// picks one requester per cycle and advances only that channel's context.
module seq_match_sched #(
  parameter logic [1:0] P0 = 2'b01,
  parameter logic [1:0] P1 = 2'b10,
  parameter logic [1:0] P2 = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [7:0] sym,
  input  logic [3:0] clr,
  output logic [3:0] gnt,
  output logic [3:0] hit,
  output logic [7:0] match_cnt
);

  typedef enum logic [1:0] {S0, S1, S2, S3} ctx_t;

  logic [1:0] r_ptr;
  logic [1:0] w_win;
  logic [3:0] w_done;
  logic [7:0] r_cnt;

  // Scan from the highest rotated offset down so the lowest offset wins.
  always_comb begin
    w_win = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[r_ptr + 2'(k)]) w_win = r_ptr + 2'(k);
    end
  end

  assign gnt = (|req) ? (4'b0001 << w_win) : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 2'd0;
    end else if (|req) begin
      r_ptr <= w_win + 2'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_ch
      ctx_t       r_ctx;
      ctx_t       w_ctx_next;
      logic [1:0] w_sym;

      assign w_sym = sym[2*gi+1 -: 2];

      always_comb begin
        w_ctx_next = r_ctx;
        if (gnt[gi]) begin
          case (r_ctx)
            S0: w_ctx_next = (w_sym == P0) ? S1 : S0;
            S1: begin
              if (w_sym == P1)      w_ctx_next = S2;
              else if (w_sym == P0) w_ctx_next = S1;
              else                  w_ctx_next = S0;
            end
            S2: begin
              if (w_sym == P2)      w_ctx_next = S3;
              else if (w_sym == P0) w_ctx_next = S1;
              else                  w_ctx_next = S0;
            end
            S3: w_ctx_next = S3;
            default: w_ctx_next = S0;
          endcase
        end
        // A clear wins over a same-cycle consume; that symbol is dropped.
        if (clr[gi]) w_ctx_next = S0;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ctx <= S0;
        end else begin
          r_ctx <= w_ctx_next;
        end
      end

      assign hit[gi]    = (r_ctx == S3);
      assign w_done[gi] = gnt[gi] && (r_ctx == S2) && (w_sym == P2) && !clr[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if ((|w_done) && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign match_cnt = r_cnt;

endmodule

// File: tb/tb_seq_match_sched.sv
// Directed bench for seq_match_sched: arbitration order, per-channel
// pattern tracking, clear/reset interaction and counter saturation.
module tb_seq_match_sched;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [7:0] sym;
  logic [3:0] clr;
  logic [3:0] gnt;
  logic [3:0] hit;
  logic [7:0] match_cnt;

  int n_cmp;
  int n_err;

  seq_match_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .sym       (sym),
    .clr       (clr),
    .gnt       (gnt),
    .hit       (hit),
    .match_cnt (match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check the combinational grant, then clock it in.
  task automatic step(input string tag, input logic [3:0] r, input logic [7:0] s,
                      input logic [3:0] c, input logic [3:0] eg);
    req = r;
    sym = s;
    clr = c;
    #1;
    $display("txn %s req=%b sym=%b clr=%b gnt=%b", tag, r, s, c, gnt);
    check({tag, "_gnt"}, 32'(gnt), 32'(eg));
    @(posedge clk);
    #1;
    req = 4'b0;
    clr = 4'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0;
    clr   = 4'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    req   = 4'b0;
    sym   = 8'b0;
    clr   = 4'b0;
    @(posedge clk);
    #1;
    do_reset();
    #1;
    check("rst_hit", 32'(hit), 32'h0);
    check("rst_cnt", 32'(match_cnt), 32'h0);
    check("rst_gnt_idle", 32'(gnt), 32'h0);

    // Single channel full match
    step("c0_a", 4'b0001, 8'b0000_0001, 4'b0, 4'b0001);
    step("c0_b", 4'b0001, 8'b0000_0010, 4'b0, 4'b0001);
    check("c0_hit_pre", 32'(hit), 32'h0);
    step("c0_c", 4'b0001, 8'b0000_0011, 4'b0, 4'b0001);
    check("c0_hit", 32'(hit), 32'h1);
    check("c0_cnt", 32'(match_cnt), 32'd1);

    // Fairness
    do_reset();
    step("rr0", 4'b1111, 8'h00, 4'b0, 4'b0001);
    step("rr1", 4'b1111, 8'h00, 4'b0, 4'b0010);
    step("rr2", 4'b1111, 8'h00, 4'b0, 4'b0100);
    step("rr3", 4'b1111, 8'h00, 4'b0, 4'b1000);
    step("rr4", 4'b1111, 8'h00, 4'b0, 4'b0001);
    check("rr_hit", 32'(hit), 32'h0);

    // Context isolation: ch0 01,10,11 / ch1 01,00,01
    do_reset();
    step("iso1", 4'b0011, 8'b0000_0101, 4'b0, 4'b0001);
    step("iso2", 4'b0011, 8'b0000_0110, 4'b0, 4'b0010);
    step("iso3", 4'b0011, 8'b0000_0010, 4'b0, 4'b0001);
    step("iso4", 4'b0011, 8'b0000_0011, 4'b0, 4'b0010);
    step("iso5", 4'b0011, 8'b0000_0111, 4'b0, 4'b0001);
    step("iso6", 4'b0010, 8'b0000_0100, 4'b0, 4'b0010);
    check("iso_hit", 32'(hit), 32'h1);
    check("iso_cnt", 32'(match_cnt), 32'd1);
    // ch1 must be sitting in S1: 10 then 11 completes it
    step("iso7", 4'b0010, 8'b0000_1000, 4'b0, 4'b0010);
    step("iso8", 4'b0010, 8'b0000_1100, 4'b0, 4'b0010);
    check("iso_hit2", 32'(hit), 32'h3);
    check("iso_cnt2", 32'(match_cnt), 32'd2);

    // Broken pattern on ch2: 01,10,10,01,10,11
    do_reset();
    step("brk1", 4'b0100, 8'b0001_0000, 4'b0, 4'b0100);
    step("brk2", 4'b0100, 8'b0010_0000, 4'b0, 4'b0100);
    step("brk3", 4'b0100, 8'b0010_0000, 4'b0, 4'b0100);
    check("brk_hit3", 32'(hit), 32'h0);
    step("brk4", 4'b0100, 8'b0001_0000, 4'b0, 4'b0100);
    step("brk5", 4'b0100, 8'b0010_0000, 4'b0, 4'b0100);
    check("brk_hit5", 32'(hit), 32'h0);
    step("brk6", 4'b0100, 8'b0011_0000, 4'b0, 4'b0100);
    check("brk_hit6", 32'(hit), 32'h4);
    check("brk_cnt", 32'(match_cnt), 32'd1);

    // clr colliding with the completing consume
    do_reset();
    step("clr1", 4'b0001, 8'b0000_0001, 4'b0000, 4'b0001);
    step("clr2", 4'b0001, 8'b0000_0010, 4'b0000, 4'b0001);
    step("clr3", 4'b0001, 8'b0000_0011, 4'b0001, 4'b0001);
    check("clr_col_hit", 32'(hit), 32'h0);
    check("clr_col_cnt", 32'(match_cnt), 32'd0);
    step("clr4", 4'b0001, 8'b0000_0001, 4'b0000, 4'b0001);
    step("clr5", 4'b0001, 8'b0000_0010, 4'b0000, 4'b0001);
    step("clr6", 4'b0001, 8'b0000_0011, 4'b0000, 4'b0001);
    check("clr_s3_hit", 32'(hit), 32'h1);
    step("clr7", 4'b0000, 8'b0000_0000, 4'b0001, 4'b0000);
    check("clr_after_hit", 32'(hit), 32'h0);
    check("clr_after_cnt", 32'(match_cnt), 32'd1);

    // Reset mid-pattern: ch3 to S2, move ptr to 1, then reset
    step("mid1", 4'b1000, 8'b0100_0000, 4'b0, 4'b1000);
    step("mid2", 4'b1000, 8'b1000_0000, 4'b0, 4'b1000);
    step("mid3", 4'b0001, 8'b0000_0000, 4'b0, 4'b0001);
    do_reset();
    #1;
    check("mid_rst_cnt", 32'(match_cnt), 32'd0);
    check("mid_rst_hit", 32'(hit), 32'h0);
    step("mid4", 4'b1111, 8'h00, 4'b0, 4'b0001);
    step("mid5", 4'b1000, 8'b1100_0000, 4'b0, 4'b1000);
    check("mid_no_hit", 32'(hit), 32'h0);
    check("mid_cnt", 32'(match_cnt), 32'd0);

    // Saturation: 257 full matches on ch0, cleared between each
    do_reset();
    for (int i = 0; i < 257; i++) begin
      step("sat_a", 4'b0001, 8'b0000_0001, 4'b0, 4'b0001);
      step("sat_b", 4'b0001, 8'b0000_0010, 4'b0, 4'b0001);
      step("sat_c", 4'b0001, 8'b0000_0011, 4'b0, 4'b0001);
      if (i == 0)   check("sat_first", 32'(match_cnt), 32'd1);
      if (i == 253) check("sat_254", 32'(match_cnt), 32'd254);
      if (i == 254) check("sat_255", 32'(match_cnt), 32'd255);
      if (i == 256) check("sat_hold", 32'(match_cnt), 32'd255);
      step("sat_clr", 4'b0000, 8'b0000_0000, 4'b0001, 4'b0000);
    end
    check("sat_final_hit", 32'(hit), 32'h0);
    check("sat_final_cnt", 32'(match_cnt), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
